mult_cs_pipe: RTL
=================

Name: mult_cs_pipe

Overview:
- Parametrised, pipelined A_W x B_W multiplier with a valid/ready handshake on both sides.
- Each transaction selects signed or unsigned mode.
- Outputs:
  - the product as a carry-save pair (out1 + out2 = product), in the same form as the existing 14x16 multiplier;
  - the resolved product;
  - an optional running accumulator for CFA filter-tap sums.
- Sits between the CFA neighbourhood buffer and the interpolation adder tree.

Parameters:
- A_W, 14, width of operand a
- B_W, 16, width of operand b
- PIPE, 3, pipeline depth in cycles (1..6)
- ACC_W, 34, accumulator width (must be >= A_W+B_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- a  in  A_W  multiplicand
- b  in  B_W  multiplier
- signed_mode  in  1  1: a and b are two's complement; 0: unsigned
- acc_en  in  1  add this product into the accumulator
- acc_clr  in  1  zero the accumulator before adding this product
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output
- out1  out  A_W+B_W  carry-save sum word
- out2  out  A_W+B_W  carry-save carry word
- prod  out  A_W+B_W  resolved product = out1+out2 mod 2^(A_W+B_W)
- acc  out  ACC_W  accumulator value

Behaviour:
- Decided: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, out1=out2=prod=0, acc=0, in_ready=1.
- Stall rule: global advance enable en = out_ready | ~out_valid, and in_ready = en. All PIPE stages shift together when en=1 and hold when en=0. Bubbles are not collapsed.
- Input acceptance: a transaction is accepted when in_valid & in_ready. a, b, signed_mode, acc_en and acc_clr are captured and travel down the pipeline with the data; later input changes do not affect in-flight work.
- Latency: exactly PIPE cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 per cycle.
- Output hold: out1, out2, prod and out_valid stay stable while out_valid & ~out_ready.
- Ordering: outputs appear in acceptance order; no loss, no duplication.
- Arithmetic:
  - Signed mode: sign-extend both operands to P=A_W+B_W.
  - Unsigned mode: zero-extend both operands to P.
  - Product is taken mod 2^P; it always fits for both modes.
  - Partial products are reduced by a Wallace/Dadda CSA tree split across stages 1..PIPE-1.
  - The final stage registers out1/out2 and the CPA result prod.
  - With PIPE=1, all of this happens in one stage.
- Carry-save invariant: (out1+out2) mod 2^P == prod whenever out_valid=1. The individual words are otherwise unconstrained.
- Accumulator:
  - Updates only on the output handshake (out_valid & out_ready) of a transaction whose captured acc_en=1.
  - New value: acc <= (acc_clr_q ? 0 : acc) + ext(prod).
  - ext(prod) is a sign extension in signed mode and a zero extension otherwise, to ACC_W.
  - Wraps mod 2^ACC_W.
  - The new value is visible the cycle after the handshake.
  - acc_clr with acc_en=0: acc <= 0 at the handshake.
- Reset mid-operation: in-flight transactions are discarded immediately (asynchronously); out_valid drops in the same cycle; no partial acc update.
- in_valid is ignored while in_ready=0. The upstream must hold the transaction; the block does not latch it.

Test Plan:
- Unsigned extremes (defaults, signed_mode=0): a=16383, b=65535 -> after 3 cycles prod=1073659905 and out1+out2 mod 2^30 = 1073659905. a=0, b=65535 -> prod=0.
- Signed corners (signed_mode=1):
  - a=14'h3FFF, b=16'hFFFF -> prod=1.
  - a=14'h2000, b=16'h8000 -> prod=30'h10000000.
  - a=14'h2000, b=16'h7FFF -> prod = -268427264 mod 2^30.
- Back-to-back streaming: 100 random a/b with mixed modes, in_valid and out_ready held high -> one result per cycle, latency 3, all match the reference model, out1+out2==prod on every valid cycle.
- Backpressure: issue 3 transactions, then drop out_ready for 4 cycles -> in_ready=0 while out_valid & ~out_ready; outputs held stable; the 3 results emerge in order once out_ready=1; no loss.
- Accumulate: send (3,5, acc_clr=1, acc_en=1), then (7,11, acc_en=1), then (2,2, acc_en=0) -> acc=15, then 92, then stays 92. Signed (-1,1, acc_en=1) next -> acc=91.
- Reset mid-flight: two transactions in the pipe, assert rst for 1 cycle -> out_valid=0 immediately, acc=0, no stale output after release. The next input yields a correct result after 3 cycles.

Source files
------------

// File: rtl/mult_cs_pipe.sv
// Pipelined A_W x B_W multiplier (signed/unsigned per transaction) with carry-save, resolved and accumulated outputs.
// Latency: PIPE cycles from input acceptance to out_valid; one transaction per cycle.
// Backpressure: all stages stall together while out_valid & ~out_ready; in_ready mirrors the advance enable.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake; a, b, signed_mode, acc_en, acc_clr captured on acceptance
//   out_valid / out_ready    output handshake; out1/out2 carry-save pair, prod = out1 + out2
//   acc                      running sum of products flagged with acc_en, updated on the output handshake
module mult_cs_pipe #(
    parameter int A_W   = 14,
    parameter int B_W   = 16,
    parameter int PIPE  = 3,
    parameter int ACC_W = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    input  logic                 signed_mode,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   out1,
    output logic [A_W+B_W-1:0]   out2,
    output logic [A_W+B_W-1:0]   prod,
    output logic [ACC_W-1:0]     acc
);

    localparam int P = A_W + B_W;

    // P partial-product rows of P bits; rows beyond the live count are zero.
    typedef logic [P-1:0][P-1:0] rows_t;

    // Row count after one layer of 3:2 compressors.
    function automatic int next_rows(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int num_levels(input int n);
        int m;
        int c;
        m = n;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (m > 2) begin
                m = next_rows(m);
                c++;
            end
        end
        return c;
    endfunction

    // One CSA layer: each full triple of live rows becomes sum/carry, leftovers pass through,
    // all packed to the low row indices so the live count stays contiguous.
    function automatic rows_t csa_level(input rows_t x, input int n);
        rows_t y;
        int    g;
        y = '0;
        g = n / 3;
        for (int i = 0; i < P / 3; i++) begin
            if (i < g) begin
                y[2*i]   = x[3*i] ^ x[3*i+1] ^ x[3*i+2];
                y[2*i+1] = ((x[3*i] & x[3*i+1]) | (x[3*i] & x[3*i+2]) |
                            (x[3*i+1] & x[3*i+2])) << 1;
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (j < n % 3) begin
                y[2*g+j] = x[3*g+j];
            end
        end
        return y;
    endfunction

    // Apply tree levels [lo, hi); the live row count is tracked from the full tree so a
    // stage in the middle of the tree knows how many rows it receives.
    function automatic rows_t reduce(input rows_t rin, input int lo, input int hi);
        rows_t r;
        int    n;
        r = rin;
        n = P;
        for (int l = 0; l < P; l++) begin
            if (n > 2) begin
                if (l >= lo && l < hi) begin
                    r = csa_level(r, n);
                end
                n = next_rows(n);
            end
        end
        return r;
    endfunction

    // Final stage only needs the two surviving rows: {carry word, sum word}.
    function automatic logic [2*P-1:0] cs_pair(input rows_t rin, input int lo, input int hi);
        rows_t r;
        r = reduce(rin, lo, hi);
        return {r[1], r[0]};
    endfunction

    localparam int L  = num_levels(P);
    // Tree levels are spread over stages 1..PIPE-1; with PIPE=1 the single stage does everything.
    localparam int NS = (PIPE > 1) ? PIPE - 1 : 1;

    logic                           w_en;
    logic [PIPE-1:0]                r_vld;
    logic [PIPE-1:0]                r_sgn;
    logic [PIPE-1:0]                r_acc_en;
    logic [PIPE-1:0]                r_acc_clr;
    logic [P-1:0]                   w_a_ext;
    logic [P-1:0]                   w_b_ext;
    rows_t                          w_pp;
    logic [PIPE-1:0][P-1:0][P-1:0]  w_st_in;
    logic [P-1:0]                   r_out1;
    logic [P-1:0]                   r_out2;
    logic [P-1:0]                   r_prod;
    logic [ACC_W-1:0]               r_acc;
    logic [ACC_W-1:0]               w_prod_ext;
    logic                           w_out_hs;

    assign w_en     = out_ready | ~r_vld[PIPE-1];
    assign in_ready = w_en;

    // Extending both operands to P bits makes the mod-2^P product correct for either mode.
    always_comb begin
        w_a_ext = {{B_W{signed_mode & a[A_W-1]}}, a};
        w_b_ext = {{A_W{signed_mode & b[B_W-1]}}, b};
    end

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < P; i++) begin
            w_pp[i] = w_b_ext[i] ? (w_a_ext << i) : '0;
        end
    end

    assign w_st_in[0] = w_pp;

    for (genvar k = 0; k < PIPE; k++) begin : g_st
        localparam int LO = ((k < NS) ? k : NS) * L / NS;
        localparam int HI = ((k + 1 < NS) ? k + 1 : NS) * L / NS;

        if (k < PIPE - 1) begin : g_mid
            rows_t w_red;
            rows_t r_rows;

            assign w_red = reduce(w_st_in[k], LO, HI);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rows <= '0;
                end else if (w_en) begin
                    r_rows <= w_red;
                end
            end

            assign w_st_in[k+1] = r_rows;
        end else begin : g_last
            logic [2*P-1:0] w_cs;

            assign w_cs = cs_pair(w_st_in[k], LO, HI);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out1 <= '0;
                    r_out2 <= '0;
                    r_prod <= '0;
                end else if (w_en) begin
                    r_out1 <= w_cs[P-1:0];
                    r_out2 <= w_cs[2*P-1:P];
                    r_prod <= w_cs[P-1:0] + w_cs[2*P-1:P];
                end
            end
        end
    end

    // Sideband travels with the data so later input changes cannot affect in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= '0;
            r_sgn     <= '0;
            r_acc_en  <= '0;
            r_acc_clr <= '0;
        end else if (w_en) begin
            r_vld[0]     <= in_valid;
            r_sgn[0]     <= signed_mode;
            r_acc_en[0]  <= acc_en;
            r_acc_clr[0] <= acc_clr;
            for (int k = 1; k < PIPE; k++) begin
                r_vld[k]     <= r_vld[k-1];
                r_sgn[k]     <= r_sgn[k-1];
                r_acc_en[k]  <= r_acc_en[k-1];
                r_acc_clr[k] <= r_acc_clr[k-1];
            end
        end
    end

    assign w_out_hs = r_vld[PIPE-1] & out_ready;

    always_comb begin
        w_prod_ext          = {ACC_W{r_sgn[PIPE-1] & r_prod[P-1]}};
        w_prod_ext[P-1:0]   = r_prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_out_hs) begin
            if (r_acc_en[PIPE-1]) begin
                r_acc <= (r_acc_clr[PIPE-1] ? '0 : r_acc) + w_prod_ext;
            end else if (r_acc_clr[PIPE-1]) begin
                r_acc <= '0;
            end
        end
    end

    assign out_valid = r_vld[PIPE-1];
    assign out1      = r_out1;
    assign out2      = r_out2;
    assign prod      = r_prod;
    assign acc       = r_acc;

endmodule
